// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus types: bridge FSM state encoding and the idle-bus byte.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } bridge_state_t;

  localparam logic [7:0] Z80_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/bridge_timeout.sv
// Loadable down-counter bounding how long a memory request may stay open.
module bridge_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/z80_mem_bridge.sv
// Turns Z80 memory strobes into one req/ack transaction per CPU cycle,
// stalling the CPU via wait_n until memory answers or the request times out.
module z80_mem_bridge
  import z80_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [7:0]  IDLE_DATA = Z80_IDLE_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        err
);

  bridge_state_t state, state_d;
  logic          strb;
  logic          capture;
  logic          tmo_load, tmo_en, tmo_expired;
  logic          mem_req_d, err_d;
  logic [7:0]    cpu_di_d;

  assign strb = !cpu_mreq_n && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n);

  // Combinational term lets the CPU see wait low on its first T2 enable.
  assign cpu_wait_n = !((state == REQ) || ((state == IDLE) && strb));

  bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      err       <= 1'b0;
      cpu_di    <= IDLE_DATA;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_d;
      mem_req <= mem_req_d;
      err     <= err_d;
      cpu_di  <= cpu_di_d;
      if (capture) begin
        mem_we    <= !cpu_wr_n;
        mem_addr  <= cpu_a;
        mem_wdata <= cpu_dout;
      end
    end
  end

  // Next state plus registered-output next values.
  always_comb begin
    state_d   = state;
    mem_req_d = mem_req;
    err_d     = err;
    cpu_di_d  = cpu_di;
    capture   = 1'b0;
    tmo_load  = 1'b0;
    tmo_en    = 1'b0;
    case (state)
      IDLE: begin
        if (strb) begin
          capture   = 1'b1;
          mem_req_d = 1'b1;
          tmo_load  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we) cpu_di_d = mem_rdata;
          state_d = HOLD;
        end else if (tmo_expired) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we) cpu_di_d = IDLE_DATA;
          state_d = HOLD;
        end else begin
          tmo_en = 1'b1;
        end
      end
      HOLD: begin
        // Waiting for the CPU to release its strobe guarantees one txn per cycle.
        if (!strb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Scoreboard bench for z80_mem_bridge with TIMEOUT=8.
module tb_z80_mem_bridge;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  z80_mem_bridge #(.TIMEOUT(8), .IDLE_DATA(8'hFF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_di     (cpu_di),
    .cpu_wait_n (cpu_wait_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  task automatic release_bus;
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  // Pop the expected request and compare it to what the DUT presents.
  task automatic sb_check(input string tag);
    txn_t e, got;
    got = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: unexpected request got %h", tag, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s_sb: got we/addr/wdata %h want %h", tag, got, e);
      end
    end
  endtask

  // One CPU memory cycle: strobe, optional ack after ack_dly clks of mem_req,
  // strobe held 'hold' clks after completion, optional spurious ack in HOLD.
  task automatic run_txn(input string tag, input bit wr, input logic [15:0] a,
                         input logic [7:0] d, input int ack_dly,
                         input logic [7:0] rdata, input int hold, input bit spur,
                         output int req_clks, output int wait_clks, output int pulses);
    int since, hold_cnt, tail;
    bit done, prev, released;
    since = 0; hold_cnt = 0; tail = 0;
    done = 1'b0; prev = mem_req; released = 1'b0;
    req_clks = 0; wait_clks = 0; pulses = 0;
    exp_q.push_back('{we: wr, addr: a, wdata: d});
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = wr;
        cpu_wr_n   = !wr;
        cpu_a      = a;
        cpu_dout   = d;
      end
      since     = mem_req ? since + 1 : 0;
      mem_ack   = (ack_dly > 0) && (since == ack_dly);
      mem_rdata = rdata;
      if (done && !released) begin
        if (spur && hold_cnt == 0) mem_ack = 1'b1;
        if (hold_cnt == hold) begin
          release_bus();
          released = 1'b1;
        end
        hold_cnt++;
      end
      @(negedge clk);
      if (!cpu_wait_n) wait_clks++;
      if (mem_req) req_clks++;
      if (mem_req && !prev) begin
        pulses++;
        sb_check(tag);
      end
      if (prev && !mem_req) done = 1'b1;
      prev = mem_req;
      if (released) begin
        tail++;
        if (tail == 4) begin
          mem_ack = 1'b0;
          return;
        end
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_budget: transaction did not finish, req_clks %0d want done", tag, req_clks);
    release_bus();
    mem_ack = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_int(input string tag, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, want);
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [43:0] got, want;
    got  = {mem_req, mem_we, mem_addr, mem_wdata, cpu_di, cpu_wait_n, err, 8'h00};
    want = {1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got req/we/addr/wdata/di/wait/err %h want %h", tag, got, want);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    release_bus();
    cpu_rfsh_n = 1'b1;
    cpu_a = 16'h0000; cpu_dout = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) check_reset_values("after_reset");
  endtask

  task automatic test_read;
    int rq, wt, pl;
    run_txn("read", 1'b0, 16'h4000, 8'h00, 3, 8'h5A, 0, 1'b0, rq, wt, pl);
    check_int("read_req_clks", rq, 3);
    check_int("read_wait_clks", wt, 4);
    check_int("read_pulses", pl, 1);
    check_int("read_di", int'(cpu_di), 8'h5A);
    check_int("read_err", int'(err), 0);
    check_int("read_wait_high", int'(cpu_wait_n), 1);
  endtask

  task automatic test_write;
    int rq, wt, pl;
    run_txn("write", 1'b1, 16'hC123, 8'hA7, 1, 8'h33, 0, 1'b0, rq, wt, pl);
    check_int("write_req_clks", rq, 1);
    check_int("write_wait_clks", wt, 2);
    check_int("write_di_kept", int'(cpu_di), 8'h5A);
  endtask

  task automatic test_refresh;
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0;
      cpu_rd_n = (v == 0); cpu_wr_n = 1'b1; cpu_a = 16'h0077;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check_int("refresh_req", int'(mem_req), 0);
        check_int("refresh_wait", int'(cpu_wait_n), 1);
      end
      release_bus();
      cpu_rfsh_n = 1'b1;
    end
  endtask

  task automatic test_timeout;
    int rq, wt, pl;
    run_txn("timeout", 1'b0, 16'h2222, 8'h00, 0, 8'h11, 0, 1'b0, rq, wt, pl);
    check_int("timeout_req_clks", rq, 8);
    check_int("timeout_wait_clks", wt, 9);
    check_int("timeout_err", int'(err), 1);
    check_int("timeout_di", int'(cpu_di), 8'hFF);
    check_int("timeout_wait_high", int'(cpu_wait_n), 1);
  endtask

  task automatic test_hold_strobe;
    int rq, wt, pl;
    run_txn("hold", 1'b0, 16'h1357, 8'h00, 2, 8'h3C, 10, 1'b1, rq, wt, pl);
    check_int("hold_pulses", pl, 1);
    check_int("hold_req_clks", rq, 2);
    check_int("hold_di", int'(cpu_di), 8'h3C);
    check_int("hold_err_sticky", int'(err), 1);
  endtask

  task automatic test_reset_mid_req;
    int cyc, rq, wt, pl;
    exp_q.push_back('{we: 1'b0, addr: 16'h8001, wdata: 8'h00});
    @(posedge clk); #1;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    cpu_a = 16'h8001; cpu_dout = 8'h00; mem_ack = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (mem_req) sb_check("rst_req");
    else begin
      check_int("rst_req_rise", int'(mem_req), 1);
      exp_q.delete();
    end
    @(posedge clk); #3;
    release_bus();
    reset_n = 1'b0;
    #1 check_reset_values("rst_mid_req");
    @(negedge clk) reset_n = 1'b1;
    run_txn("post_rst", 1'b0, 16'h1234, 8'h00, 2, 8'h99, 0, 1'b0, rq, wt, pl);
    check_int("post_rst_req_clks", rq, 2);
    check_int("post_rst_di", int'(cpu_di), 8'h99);
    check_int("post_rst_err", int'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_refresh();
    test_timeout();
    test_hold_strobe();
    test_reset_mid_req();
    check_int("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
